// File: rtl/spi_engine_mc_pkg.sv
// Shared definitions for the spi_engine_mc SPI master shift engine:
// FSM state encoding and default parameter values.
package spi_engine_mc_pkg;

    localparam int MAX_WIDTH_DEF = 32;
    localparam int NUM_CS_DEF    = 4;
    localparam int PSCL_W_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/spi_engine_mc_if.sv
// SPI pin bundle between the shift engine and the pads.
// master: drives SCK/MOSI/CS_n, reads MISO. slave: the opposite.
interface spi_engine_mc_if #(
    parameter int NUM_CS = 4
);
    logic              spi_clk_o;
    logic              spi_mosi_o;
    logic              spi_miso_i;
    logic [NUM_CS-1:0] spi_cs_n_o;

    modport master (
        output spi_clk_o,
        output spi_mosi_o,
        output spi_cs_n_o,
        input  spi_miso_i
    );

    modport slave (
        input  spi_clk_o,
        input  spi_mosi_o,
        input  spi_cs_n_o,
        output spi_miso_i
    );
endinterface

// File: rtl/spi_engine_mc_clk_div.sv
// Half-period tick generator: counts 0..pscl and pulses tick at pscl.
// Ports: clk, rst (sync), clr (hold counter at 0), pscl, tick.
module spi_engine_mc_clk_div #(
    parameter int PSCL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [PSCL_W-1:0] pscl,
    output logic              tick
);
    logic [PSCL_W-1:0] cnt_q;
    logic [PSCL_W-1:0] cnt_d;

    assign tick = !clr && (cnt_q == pscl);

    always_comb begin
        cnt_d = cnt_q + PSCL_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spi_engine_mc.sv
// SPI master shift engine: 1..MAX_WIDTH bit transfers, CPOL/CPHA modes,
// MSB/LSB order, prescaled SCK, NUM_CS chip selects with optional hold.
// Ports: spi_clk_in, rst (sync high), spi_begin + config + data_mosi in,
// data_miso/spi_busy/spi_done out, pins (SCK/MOSI/MISO/CS_n interface).
module spi_engine_mc
    import spi_engine_mc_pkg::*;
#(
    parameter int MAX_WIDTH = MAX_WIDTH_DEF,
    parameter int NUM_CS    = NUM_CS_DEF,
    parameter int PSCL_W    = PSCL_W_DEF,
    localparam int XW = $clog2(MAX_WIDTH),
    localparam int CW = $clog2(NUM_CS),
    localparam int EW = XW + 1
) (
    input  logic                 spi_clk_in,
    input  logic                 rst,
    input  logic                 spi_begin,
    input  logic [XW-1:0]        xfer_bits,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 lsb_first,
    input  logic [CW-1:0]        cs_sel,
    input  logic                 cs_hold,
    input  logic                 cs_release,
    input  logic [PSCL_W-1:0]    pscl,
    input  logic [MAX_WIDTH-1:0] data_mosi,
    output logic [MAX_WIDTH-1:0] data_miso,
    output logic                 spi_busy,
    output logic                 spi_done,
    spi_engine_mc_if.master      pins
);
    state_e                state_q, state_d;
    logic [XW-1:0]         xfer_q, xfer_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;
    logic                  hold_q, hold_d;
    logic [PSCL_W-1:0]     pscl_q, pscl_d;
    logic [MAX_WIDTH-1:0]  tx_q, tx_d;
    logic [MAX_WIDTH-1:0]  rx_q, rx_d;
    logic [MAX_WIDTH-1:0]  miso_q, miso_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic [XW-1:0]         bit_j;
    logic [XW-1:0]         idx;
    logic [XW-1:0]         idx_nx;

    // Counter idles at 0 in IDLE; every other state change happens on a
    // tick, where the counter wraps, so each state starts from 0.
    spi_engine_mc_clk_div #(.PSCL_W(PSCL_W)) u_div (
        .clk  (spi_clk_in),
        .rst  (rst),
        .clr  (state_q == ST_IDLE),
        .pscl (pscl_q),
        .tick (tick)
    );

    // Two SCK edges per bit: bit slot is the edge count halved. TX and RX
    // use the same slot-to-bit mapping so RX mirrors TX order.
    assign bit_j  = edge_q[EW-1:1];
    assign idx    = lsb_q ? bit_j : xfer_q - bit_j;
    assign idx_nx = lsb_q ? bit_j + XW'(1) : xfer_q - bit_j - XW'(1);

    always_comb begin
        state_d = state_q;
        xfer_d  = xfer_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        hold_d  = hold_q;
        pscl_d  = pscl_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        miso_d  = miso_q;
        edge_d  = edge_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (spi_begin) begin
                    state_d = ST_SETUP;
                    xfer_d  = xfer_bits;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    hold_d  = cs_hold;
                    pscl_d  = pscl;
                    tx_d    = data_mosi;
                    rx_d    = '0;
                    edge_d  = '0;
                    sck_d   = cpol;
                    // Same index as a held CS leaves that bit unchanged.
                    for (int i = 0; i < NUM_CS; i++) begin
                        cs_n_d[i] = (cs_sel != CW'(i));
                    end
                    if (!cpha) begin
                        mosi_d = lsb_first ? data_mosi[0]
                                           : data_mosi[xfer_bits];
                    end
                end else if (cs_release) begin
                    cs_n_d = '1;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sck_d  = ~sck_q;
                    edge_d = edge_q + EW'(1);
                    // Sample edge parity equals cpha; the other edge shifts.
                    if (edge_q[0] == cpha_q) begin
                        rx_d[idx] = pins.spi_miso_i;
                    end else if (cpha_q) begin
                        mosi_d = tx_q[idx];
                    end else if (bit_j != xfer_q) begin
                        mosi_d = tx_q[idx_nx];
                    end
                    if (edge_q == {xfer_q, 1'b1}) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    miso_d  = rx_q;
                    if (!hold_q) begin
                        cs_n_d = '1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge spi_clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
            xfer_q  <= '0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            hold_q  <= 1'b0;
            pscl_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            miso_q  <= '0;
            edge_q  <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xfer_q  <= xfer_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            hold_q  <= hold_d;
            pscl_q  <= pscl_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            miso_q  <= miso_d;
            edge_q  <= edge_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
        end
    end

    assign data_miso       = miso_q;
    assign spi_busy        = (state_q != ST_IDLE);
    assign spi_done        = done_q;
    assign pins.spi_clk_o  = sck_q;
    assign pins.spi_mosi_o = mosi_q;
    assign pins.spi_cs_n_o = cs_n_q;
endmodule

// File: tb/tb_spi_engine_mc.sv
// Self-checking bench for spi_engine_mc with MISO looped back as ~MOSI
// and expectations computed from transfer length, mode and bit order.
module tb_spi_engine_mc;
    localparam int MW = 32;
    localparam int NC = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          spi_begin = 1'b0;
    logic [4:0]    xfer_bits = '0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          lsb_first = 1'b0;
    logic [1:0]    cs_sel = '0;
    logic          cs_hold = 1'b0;
    logic          cs_release = 1'b0;
    logic [PW-1:0] pscl = '0;
    logic [MW-1:0] data_mosi = '0;
    logic [MW-1:0] data_miso;
    logic          spi_busy;
    logic          spi_done;

    int n_chk  = 0;
    int n_fail = 0;
    logic [NC-1:0] cs_model = '1;

    always #5 clk = ~clk;

    spi_engine_mc_if #(.NUM_CS(NC)) pins ();
    assign pins.spi_miso_i = ~pins.spi_mosi_o;

    spi_engine_mc #(.MAX_WIDTH(MW), .NUM_CS(NC), .PSCL_W(PW)) dut (
        .spi_clk_in (clk),
        .rst        (rst),
        .spi_begin  (spi_begin),
        .xfer_bits  (xfer_bits),
        .cpol       (cpol),
        .cpha       (cpha),
        .lsb_first  (lsb_first),
        .cs_sel     (cs_sel),
        .cs_hold    (cs_hold),
        .cs_release (cs_release),
        .pscl       (pscl),
        .data_mosi  (data_mosi),
        .data_miso  (data_miso),
        .spi_busy   (spi_busy),
        .spi_done   (spi_done),
        .pins       (pins.master)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NC-1:0] dec(input int s);
        logic [NC-1:0] v;
        v = '1;
        if (s < NC) v[s] = 1'b0;
        return v;
    endfunction

    task automatic xfer(input int xb, input bit cp, input bit ch,
                        input bit lsb, input int sel, input bit hold,
                        input int ps, input logic [31:0] data,
                        input bit rel, input bit poke);
        int n;
        int cyc;
        int edges;
        logic prev;
        logic [31:0] got;
        logic [31:0] expb;
        logic [63:0] m;
        bit cs_bad;
        logic [NC-1:0] csx;
        n = xb + 1;
        cyc = 0;
        edges = 0;
        got = '0;
        expb = '0;
        cs_bad = 0;
        csx = dec(sel);
        check("cs_idle", 64'(pins.spi_cs_n_o), 64'(cs_model));
        xfer_bits  = 5'(xb);
        cpol       = cp;
        cpha       = ch;
        lsb_first  = lsb;
        cs_sel     = 2'(sel);
        cs_hold    = hold;
        pscl       = 8'(ps);
        data_mosi  = data;
        cs_release = rel;
        spi_begin  = 1'b1;
        step();
        spi_begin  = 1'b0;
        cs_release = 1'b0;
        // Inputs scrambled after acceptance; the engine must use latched values.
        data_mosi  = $urandom;
        cpol       = ~cp;
        cpha       = ~ch;
        lsb_first  = ~lsb;
        pscl       = 8'($urandom);
        xfer_bits  = 5'($urandom);
        cs_sel     = 2'($urandom);
        cs_hold    = ~hold;
        prev = cp;
        while (spi_busy === 1'b1 && cyc < 400) begin
            cyc++;
            if (pins.spi_cs_n_o !== csx) cs_bad = 1;
            if (pins.spi_clk_o !== prev) begin
                if ((edges % 2) == int'(ch) && (edges / 2) < 32)
                    got[edges/2] = pins.spi_mosi_o;
                edges++;
                prev = pins.spi_clk_o;
            end
            spi_begin  = poke && (cyc == 3);
            cs_release = poke && (cyc == 3);
            step();
        end
        spi_begin  = 1'b0;
        cs_release = 1'b0;
        for (int k = 0; k < n; k++)
            expb[k] = lsb ? data[k] : data[xb-k];
        m = (64'd1 << n) - 64'd1;
        check("busy_cycles", 64'(cyc), 64'((ps + 1) * (2 * n + 2)));
        check("done", 64'(spi_done), 64'd1);
        check("data_miso", 64'(data_miso), 64'(~data & m[31:0]));
        check("sck_edges", 64'(edges), 64'(2 * n));
        check("mosi_bits", 64'(got), 64'(expb));
        check("sck_idle", 64'(pins.spi_clk_o), 64'(cp));
        check("cs_during", 64'(cs_bad), 64'd0);
        cs_model = hold ? csx : '1;
        check("cs_after", 64'(pins.spi_cs_n_o), 64'(cs_model));
        step();
        check("done_pulse", 64'(spi_done), 64'd0);
        check("miso_held", 64'(data_miso), 64'(~data & m[31:0]));
    endtask

    initial begin
        int edges;
        int cyc;
        logic prev;
        bit saw;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_cs", 64'(pins.spi_cs_n_o), 64'hF);
        check("rst_sck", 64'(pins.spi_clk_o), 64'd0);
        check("rst_mosi", 64'(pins.spi_mosi_o), 64'd0);
        check("rst_busy", 64'(spi_busy), 64'd0);
        check("rst_done", 64'(spi_done), 64'd0);
        check("rst_miso", 64'(data_miso), 64'd0);
        step();

        xfer(7, 0, 0, 0, 0, 0, 0, 32'hA5, 0, 0);
        check("ex1_miso", 64'(data_miso), 64'h5A);
        xfer(31, 1, 1, 0, 2, 0, 2, 32'h67676767, 0, 0);
        check("ex2_miso", 64'(data_miso), 64'h98989898);
        xfer(7, 0, 0, 1, 3, 0, 0, 32'h17, 0, 0);
        check("ex3_miso", 64'(data_miso), 64'hE8);

        xfer(7, 0, 1, 0, 1, 1, 0, $urandom, 0, 0);
        xfer(7, 1, 0, 0, 1, 1, 1, $urandom, 1, 0);
        check("held_cs1", 64'(pins.spi_cs_n_o), 64'hD);
        step();
        check("held_idle", 64'(pins.spi_cs_n_o), 64'hD);
        cs_release = 1'b1;
        step();
        cs_release = 1'b0;
        cs_model = '1;
        check("cs_release", 64'(pins.spi_cs_n_o), 64'hF);

        xfer(5, 0, 0, 1, 1, 1, 0, $urandom, 0, 0);
        xfer(12, 1, 1, 1, 2, 0, 1, $urandom, 0, 0);

        for (int t = 0; t < 8; t++) begin
            xfer($urandom_range(0, 31), 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                 $urandom_range(0, 3), $urandom, 1'($urandom), t[0]);
        end

        cs_hold   = 1'b1;
        cs_sel    = 2'd2;
        xfer_bits = 5'd15;
        pscl      = 8'd1;
        cpol      = 1'b0;
        cpha      = 1'b0;
        data_mosi = 32'h1234;
        spi_begin = 1'b1;
        step();
        spi_begin = 1'b0;
        edges = 0;
        cyc = 0;
        prev = 1'b0;
        while (edges < 5 && cyc < 200) begin
            cyc++;
            spi_begin = (cyc == 2);
            if (pins.spi_clk_o !== prev) begin
                edges++;
                prev = pins.spi_clk_o;
            end
            if (edges < 5) step();
        end
        spi_begin = 1'b0;
        check("reach_edge5", 64'(edges), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cs_model = '1;
        check("mid_rst_cs", 64'(pins.spi_cs_n_o), 64'hF);
        check("mid_rst_busy", 64'(spi_busy), 64'd0);
        check("mid_rst_miso", 64'(data_miso), 64'd0);
        check("mid_rst_done", 64'(spi_done), 64'd0);
        check("mid_rst_sck", 64'(pins.spi_clk_o), 64'd0);
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            if (spi_done !== 1'b0 || spi_busy !== 1'b0) saw = 1;
            step();
        end
        check("no_done_after_rst", 64'(saw), 64'd0);
        check("rst_miso_stays", 64'(data_miso), 64'd0);

        xfer(3, 0, 0, 0, 0, 0, 0, 32'h9, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
